writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Write-side driver of the 16x16 register file: buffers execute-stage results and issues them on the
//  regfile write port (we3/wa3/wd3), at most one per cycle. Write to R15 (PC) diverted to a PC-update
//  output, never to regfile. Provides forwarding lookup for the two read addresses so decode sees
//  results still queued. Sits between execute stage and regfile.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  DATA_W  16  register/data width
//  ADDR_W  4   register address width (R0..R15)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  result_valid   in   1       execute stage offers a result
//  result_ready   out  1       queue accepts result this cycle
//  result_addr    in   ADDR_W  destination register
//  result_data    in   DATA_W  value to write
//  wb_stall       in   1       1 = regfile write port unavailable, hold head
//  we3            out  1       regfile write enable
//  wa3            out  ADDR_W  regfile write address
//  wd3            out  DATA_W  regfile write data
//  pc_write_valid out  1       head entry targets R15; PC update this cycle
//  pc_write_data  out  DATA_W  new PC value
//  lookup_addr1   in   ADDR_W  decode read address 1
//  lookup_addr2   in   ADDR_W  decode read address 2
//  fwd_hit1       out  1       newest pending write to lookup_addr1 exists
//  fwd_data1      out  DATA_W  its data (0 when no hit)
//  fwd_hit2       out  1       as fwd_hit1 for lookup_addr2
//  fwd_data2      out  DATA_W  as fwd_data1 for lookup_addr2
//  pending_count  out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset (sync, high): wr_ptr=rd_ptr=count=0, all entries invalid; every output 0 except
//    result_ready=1. Reset mid-operation discards pending entries with no write issued that edge.
//  - Enqueue: result_valid && result_ready at edge -> entry {addr,data} at wr_ptr; wr_ptr+1 mod DEPTH.
//  - result_ready = (count != DEPTH); no same-cycle pass-through when full (even if dequeuing).
//  - Dequeue: count!=0 && !wb_stall -> head retired at edge; rd_ptr+1 mod DEPTH.
//  - Head outputs combinational from head entry, gated by dequeue condition:
//    addr!=15: we3=1, wa3=addr, wd3=data, pc_write_valid=0.
//    addr==15: we3=0, pc_write_valid=1, pc_write_data=data. Other case drives 0s.
//  - Latency: result accepted at edge N is written to regfile at edge N+1 at earliest (no bypass).
//  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance; legal when empty? no
//    (empty -> no dequeue), legal at any 0<count<DEPTH.
//  - Forwarding (combinational): compare lookup_addrX against all valid entries incl. head;
//    newest (closest to wr_ptr) match wins. lookup 15 never hits (PC from regfile). R0 forwards
//    normally (no hardwired zero).
//  - Pointer wrap: ADDR-of-entry pointers are $clog2(DEPTH) bits, wrap naturally; count disambiguates
//    full vs empty.
//  - pending_count = count, updated at edge.
// STRUCTURE
//  - cpu_pkg: DATA_W, ADDR_W, localparam PC_REG=4'd15, typedef struct packed {logic [ADDR_W-1:0]
//    addr; logic [DATA_W-1:0] data;} wb_entry_t.
//  - One sub-module: wb_fwd_match (priority match of one lookup address over DEPTH entries,
//    oldest-to-newest ordering from rd_ptr); instantiated twice.
// TESTING
//  1 Reset: assert reset 2 cycles with result_valid=1 -> we3=0, pending_count=0, result_ready=1.
//  2 Single write: enqueue R3=9 -> next cycle we3=1,wa3=3,wd3=9; following cycle we3=0, count=0.
//  3 Fill/stall: wb_stall=1, enqueue R1..R4 = 1..4 -> result_ready=0, count=4; 5th offer
//    (R5=5) not taken; release stall -> writes R1..R4 in order on 4 consecutive cycles.
//  4 Forwarding: stall, enqueue R6=5 then R6=7, lookup_addr1=6 -> fwd_hit1=1,fwd_data1=7;
//    lookup_addr2=2 -> fwd_hit2=0,fwd_data2=0; lookup 15 -> no hit.
//  5 PC divert: enqueue R15=4 -> pc_write_valid=1,pc_write_data=4, we3=0.
//  6 Wrap+reset: 10 back-to-back enqueue/dequeue with alternating stall, check order/count;
//    reset with 3 pending -> no further we3, count=0 after edge.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared widths, PC register index and queue entry type
package writeback_queue_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - execute-stage result handshake into the writeback queue
interface writeback_queue_if;
    import writeback_queue_pkg::*;

    logic              result_valid;
    logic              result_ready;
    logic [ADDR_W-1:0] result_addr;
    logic [DATA_W-1:0] result_data;

    modport master (
        output result_valid,
        output result_addr,
        output result_data,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_addr,
        input  result_data,
        output result_ready
    );

endinterface

// File: rtl/writeback_queue_fwd_match.sv
// rtl/writeback_queue_fwd_match.sv - newest-wins match of one read address over queued results
module wb_fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                 entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  rd_ptr_i,
    input  logic [$clog2(DEPTH):0]    count_i,
    input  logic                      enable_i,
    input  logic [ADDR_W-1:0]         lookup_addr_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk from the head towards the tail; later (newer) matches overwrite earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_i + PTR_W'(i);
            if (enable_i && (lookup_addr_i != PC_REG) && (CNT_W'(i) < count_i) &&
                (entries_i[idx].addr == lookup_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - buffers execute results and drives the regfile write port / PC update
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    writeback_queue_if.slave          res,
    input  logic                      wb_stall,
    output logic                      we3,
    output logic [ADDR_W-1:0]         wa3,
    output logic [DATA_W-1:0]         wd3,
    output logic                      pc_write_valid,
    output logic [DATA_W-1:0]         pc_write_data,
    input  logic [ADDR_W-1:0]         lookup_addr1,
    input  logic [ADDR_W-1:0]         lookup_addr2,
    output logic                      fwd_hit1,
    output logic [DATA_W-1:0]         fwd_data1,
    output logic                      fwd_hit2,
    output logic [DATA_W-1:0]         fwd_data2,
    output logic [$clog2(DEPTH):0]    pending_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entry_q [DEPTH];
    wb_entry_t        head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // While reset is held the queue looks empty and idle, so nothing reaches the regfile.
    assign res.result_ready = reset || (count_q != CNT_W'(DEPTH));
    assign push             = res.result_valid && (count_q != CNT_W'(DEPTH));
    assign pop              = !reset && (count_q != '0) && !wb_stall;
    assign head             = entry_q[rd_ptr_q];
    assign pending_count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                entry_q[wr_ptr_q] <= '{addr: res.result_addr, data: res.result_data};
            end
        end
    end

    // R15 is the PC: the head is diverted to the PC-update port instead of the regfile.
    always_comb begin
        we3            = 1'b0;
        wa3            = '0;
        wd3            = '0;
        pc_write_valid = 1'b0;
        pc_write_data  = '0;
        if (pop) begin
            if (head.addr == PC_REG) begin
                pc_write_valid = 1'b1;
                pc_write_data  = head.data;
            end else begin
                we3 = 1'b1;
                wa3 = head.addr;
                wd3 = head.data;
            end
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i     (entry_q),
        .rd_ptr_i      (rd_ptr_q),
        .count_i       (count_q),
        .enable_i      (!reset),
        .lookup_addr_i (lookup_addr1),
        .hit_o         (fwd_hit1),
        .data_o        (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i     (entry_q),
        .rd_ptr_i      (rd_ptr_q),
        .count_i       (count_q),
        .enable_i      (!reset),
        .lookup_addr_i (lookup_addr2),
        .hit_o         (fwd_hit2),
        .data_o        (fwd_data2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed vector bench for writeback_queue
module tb_writeback_queue;

    logic        clk;
    logic        reset;
    logic        wb_stall;
    logic        we3;
    logic [3:0]  wa3;
    logic [15:0] wd3;
    logic        pc_write_valid;
    logic [15:0] pc_write_data;
    logic [3:0]  lookup_addr1;
    logic [3:0]  lookup_addr2;
    logic        fwd_hit1;
    logic [15:0] fwd_data1;
    logic        fwd_hit2;
    logic [15:0] fwd_data2;
    logic [2:0]  pending_count;

    int n_chk  = 0;
    int n_fail = 0;

    writeback_queue_if rif ();

    writeback_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .res            (rif),
        .wb_stall       (wb_stall),
        .we3            (we3),
        .wa3            (wa3),
        .wd3            (wd3),
        .pc_write_valid (pc_write_valid),
        .pc_write_data  (pc_write_data),
        .lookup_addr1   (lookup_addr1),
        .lookup_addr2   (lookup_addr2),
        .fwd_hit1       (fwd_hit1),
        .fwd_data1      (fwd_data1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data2      (fwd_data2),
        .pending_count  (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic [15:0] d;
        logic        st;
        logic [3:0]  l1;
        logic [3:0]  l2;
        logic        rdy;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        pcv;
        logic [15:0] pcd;
        logic        h1;
        logic [15:0] f1;
        logic        h2;
        logic [15:0] f2;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(int v, int a, int d, int st, int l1, int l2,
                                int rdy, int we, int wa, int wd, int pcv, int pcd,
                                int h1, int f1, int h2, int f2, int cnt);
        vec_t r;
        r.v = v[0];     r.a = a[3:0];     r.d = d[15:0];    r.st = st[0];
        r.l1 = l1[3:0]; r.l2 = l2[3:0];   r.rdy = rdy[0];   r.we = we[0];
        r.wa = wa[3:0]; r.wd = wd[15:0];  r.pcv = pcv[0];   r.pcd = pcd[15:0];
        r.h1 = h1[0];   r.f1 = f1[15:0];  r.h2 = h2[0];     r.f2 = f2[15:0];
        r.cnt = cnt[2:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d,
                         input logic st, input logic [3:0] l1, input logic [3:0] l2);
        rif.result_valid = v;
        rif.result_addr  = a;
        rif.result_data  = d;
        wb_stall         = st;
        lookup_addr1     = l1;
        lookup_addr2     = l2;
    endtask

    vec_t vecs [26];
    int   mq_a [$];
    int   mq_d [$];

    initial begin
        // v  a   d       st l1  l2   rdy we wa wd      pcv pcd h1 f1      h2 f2      cnt
        vecs[0]  = mk(1, 3, 9,      0, 3,  0,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[1]  = mk(0, 0, 0,      0, 3,  0,   1, 1, 3, 9,      0, 0, 1, 9,      0, 0,      1);
        vecs[2]  = mk(0, 0, 0,      0, 3,  0,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[3]  = mk(1, 1, 1,      1, 0,  0,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[4]  = mk(1, 2, 2,      1, 1,  0,   1, 0, 0, 0,      0, 0, 1, 1,      0, 0,      1);
        vecs[5]  = mk(1, 3, 3,      1, 9,  9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      2);
        vecs[6]  = mk(1, 4, 4,      1, 9,  9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      3);
        vecs[7]  = mk(1, 5, 5,      1, 4,  5,   0, 0, 0, 0,      0, 0, 1, 4,      0, 0,      4);
        vecs[8]  = mk(0, 0, 0,      0, 9,  9,   0, 1, 1, 1,      0, 0, 0, 0,      0, 0,      4);
        vecs[9]  = mk(0, 0, 0,      0, 9,  9,   1, 1, 2, 2,      0, 0, 0, 0,      0, 0,      3);
        vecs[10] = mk(0, 0, 0,      0, 9,  9,   1, 1, 3, 3,      0, 0, 0, 0,      0, 0,      2);
        vecs[11] = mk(0, 0, 0,      0, 9,  9,   1, 1, 4, 4,      0, 0, 0, 0,      0, 0,      1);
        vecs[12] = mk(0, 0, 0,      0, 9,  9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[13] = mk(1, 6, 5,      1, 9,  9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[14] = mk(1, 6, 7,      1, 6,  9,   1, 0, 0, 0,      0, 0, 1, 5,      0, 0,      1);
        vecs[15] = mk(0, 0, 0,      1, 6,  2,   1, 0, 0, 0,      0, 0, 1, 7,      0, 0,      2);
        vecs[16] = mk(0, 0, 0,      1, 15, 6,   1, 0, 0, 0,      0, 0, 0, 0,      1, 7,      2);
        vecs[17] = mk(0, 0, 0,      0, 6,  9,   1, 1, 6, 5,      0, 0, 1, 7,      0, 0,      2);
        vecs[18] = mk(0, 0, 0,      0, 6,  9,   1, 1, 6, 7,      0, 0, 1, 7,      0, 0,      1);
        vecs[19] = mk(1, 15, 4,     0, 15, 9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[20] = mk(0, 0, 0,      0, 15, 9,   1, 0, 0, 0,      1, 4, 0, 0,      0, 0,      1);
        vecs[21] = mk(0, 0, 0,      0, 15, 9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[22] = mk(1, 0, 'h1234, 0, 0,  9,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);
        vecs[23] = mk(1, 7, 'hBEEF, 0, 0,  7,   1, 1, 0, 'h1234, 0, 0, 1, 'h1234, 0, 0,      1);
        vecs[24] = mk(0, 0, 0,      0, 9,  7,   1, 1, 7, 'hBEEF, 0, 0, 0, 0,      1, 'hBEEF, 1);
        vecs[25] = mk(0, 0, 0,      0, 9,  7,   1, 0, 0, 0,      0, 0, 0, 0,      0, 0,      0);

        // Reset held two cycles with an offer present: nothing is taken or written.
        reset = 1'b1;
        drive(1'b1, 4'd9, 16'd9, 1'b0, 4'd9, 4'd9);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rst%0d.we3", c), 32'(we3), 32'd0);
            chk($sformatf("rst%0d.ready", c), 32'(rif.result_ready), 32'd1);
            chk($sformatf("rst%0d.count", c), 32'(pending_count), 32'd0);
            chk($sformatf("rst%0d.hit1", c), 32'(fwd_hit1), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd9, 4'd9);
        @(negedge clk);
        chk("post_rst.count", 32'(pending_count), 32'd0);
        chk("post_rst.pcv", 32'(pc_write_valid), 32'd0);

        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].st, vecs[i].l1, vecs[i].l2);
            @(negedge clk);
            chk($sformatf("v%0d.ready", i), 32'(rif.result_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.we3", i),   32'(we3),            32'(vecs[i].we));
            chk($sformatf("v%0d.wa3", i),   32'(wa3),            32'(vecs[i].wa));
            chk($sformatf("v%0d.wd3", i),   32'(wd3),            32'(vecs[i].wd));
            chk($sformatf("v%0d.pcv", i),   32'(pc_write_valid), 32'(vecs[i].pcv));
            chk($sformatf("v%0d.pcd", i),   32'(pc_write_data),  32'(vecs[i].pcd));
            chk($sformatf("v%0d.hit1", i),  32'(fwd_hit1),       32'(vecs[i].h1));
            chk($sformatf("v%0d.fwd1", i),  32'(fwd_data1),      32'(vecs[i].f1));
            chk($sformatf("v%0d.hit2", i),  32'(fwd_hit2),       32'(vecs[i].h2));
            chk($sformatf("v%0d.fwd2", i),  32'(fwd_data2),      32'(vecs[i].f2));
            chk($sformatf("v%0d.count", i), 32'(pending_count),  32'(vecs[i].cnt));
        end

        // Back-to-back offers with alternating stall, against a small FIFO model.
        for (int k = 0; k < 10; k++) begin
            logic st;
            logic exp_pop;
            st = k[0];
            @(posedge clk); #1;
            drive(1'b1, 4'(k), 16'('h100 + k), st, 4'd15, 4'd15);
            @(negedge clk);
            exp_pop = (mq_a.size() > 0) && !st;
            chk($sformatf("wrap%0d.count", k), 32'(pending_count), 32'(mq_a.size()));
            chk($sformatf("wrap%0d.ready", k), 32'(rif.result_ready), 32'(mq_a.size() != 4));
            chk($sformatf("wrap%0d.we3", k), 32'(we3), 32'(exp_pop));
            if (exp_pop) begin
                chk($sformatf("wrap%0d.wa3", k), 32'(wa3), 32'(mq_a[0]));
                chk($sformatf("wrap%0d.wd3", k), 32'(wd3), 32'(mq_d[0]));
            end
            if (mq_a.size() != 4) begin
                mq_a.push_back(k);
                mq_d.push_back('h100 + k);
            end
            if (exp_pop) begin
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
        end

        // Drain one entry so exactly three remain.
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd15, 4'd15);
        @(negedge clk);
        chk("drain.count", 32'(pending_count), 32'd4);
        chk("drain.we3", 32'(we3), 32'd1);
        chk("drain.wa3", 32'(wa3), 32'(mq_a[0]));
        chk("drain.wd3", 32'(wd3), 32'(mq_d[0]));

        // Reset with three pending: no write on the reset edge, queue empty afterwards.
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 4'd2, 16'h55, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        chk("rst3.count_before", 32'(pending_count), 32'd3);
        chk("rst3.we3", 32'(we3), 32'd0);
        chk("rst3.pcv", 32'(pc_write_valid), 32'd0);
        chk("rst3.ready", 32'(rif.result_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd2, 4'd8);
        @(negedge clk);
        chk("rst3.count_after", 32'(pending_count), 32'd0);
        chk("rst3.we3_after", 32'(we3), 32'd0);
        chk("rst3.hit1_after", 32'(fwd_hit1), 32'd0);
        chk("rst3.hit2_after", 32'(fwd_hit2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
